// File: rtl/digit_frame_sync.sv
// digit_frame_sync
// Buffers one digit code from a producer and commits it to video_gen only on a
// frame boundary (vSync falling edge), so a frame never shows a half-updated
// digit. Also picks the caption string via a 4-bit LFSR and drops back to the
// instruction screen after an idle timeout.
//
// state | meaning
// ------+---------------------------------------------------------------
// INSTR | instruction screen shown, digitEn=0, txtSelect=0
// SHOW  | committed digit shown, idle timer running between commits
module digit_frame_sync #(
    parameter logic [9:0] TIMEOUT_FRAMES = 10'd600,
    parameter logic [3:0] OPTIONS        = 4'd10,
    parameter logic [3:0] LFSR_SEED      = 4'b0011
) (
    input  logic       pixClk,
    input  logic       reset,
    input  logic       vSync,
    input  logic [3:0] inDigit,
    input  logic       inValid,
    output logic       inReady,
    output logic [3:0] digit,
    output logic       digitEn,
    output logic [3:0] txtSelect,
    output logic       frameTick,
    output logic       badDigit
);

    typedef enum logic {
        INSTR = 1'b0,
        SHOW  = 1'b1
    } state_t;

    // The idle timer is a down-counter loaded on each commit; it times out at
    // the TIMEOUT_FRAMES-th boundary after the last commit.
    localparam logic [9:0] TIMER_LOAD    = TIMEOUT_FRAMES - 10'd1;
    localparam logic       TIMER_ENABLED = (TIMEOUT_FRAMES != 10'd0);

    state_t     state;
    state_t     stateNxt;

    logic       vSyncPrev;
    logic       fs;
    logic [3:0] lfsr;
    logic [3:0] lfsrMapped;

    logic       pendValid;
    logic       pendValidNxt;
    logic [3:0] pendDigit;
    logic       accept;
    logic       codeOk;
    logic       commit;

    logic [9:0] remain;
    logic [9:0] remainNxt;
    logic       timeoutHit;
    logic [3:0] digitNxt;
    logic [3:0] txtSelectNxt;

    assign fs         = vSyncPrev & ~vSync;
    assign accept     = inValid & inReady;
    assign codeOk     = (inDigit <= 4'd9);
    assign commit     = fs & pendValid;
    assign timeoutHit = TIMER_ENABLED && (remain == 10'd0);
    // Fold LFSR values past the last caption back into the caption range.
    assign lfsrMapped = (lfsr < OPTIONS) ? lfsr : (lfsr - 4'd6);

    // Frame boundary detection, frame tick pulse and caption LFSR.
    always_ff @(posedge pixClk or posedge reset) begin
        if (reset) begin
            vSyncPrev <= 1'b1;
            frameTick <= 1'b0;
            lfsr      <= LFSR_SEED;
        end else begin
            vSyncPrev <= vSync;
            frameTick <= fs;
            if (fs) begin
                lfsr <= {lfsr[2:0], lfsr[3] ^ lfsr[2]};
            end
        end
    end

    // Next occupancy of the one-entry buffer; accept only happens when empty,
    // so it can never collide with a commit on the same edge.
    always_comb begin
        pendValidNxt = pendValid;
        if (commit) begin
            pendValidNxt = 1'b0;
        end else if (accept && codeOk) begin
            pendValidNxt = 1'b1;
        end
    end

    // Producer handshake: buffer register, ready flag and bad-code pulse.
    always_ff @(posedge pixClk or posedge reset) begin
        if (reset) begin
            pendValid <= 1'b0;
            pendDigit <= 4'd0;
            inReady   <= 1'b1;
            badDigit  <= 1'b0;
        end else begin
            pendValid <= pendValidNxt;
            inReady   <= ~pendValidNxt;
            badDigit  <= accept & ~codeOk;
            if (accept && codeOk) begin
                pendDigit <= inDigit;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge pixClk or posedge reset) begin
        if (reset) begin
            state <= INSTR;
        end else begin
            state <= stateNxt;
        end
    end

    // FSM next state: commits force SHOW, an expired idle timer returns to INSTR.
    always_comb begin
        stateNxt = state;
        if (commit) begin
            stateNxt = SHOW;
        end else if (fs && (state == SHOW) && timeoutHit) begin
            stateNxt = INSTR;
        end
    end

    // FSM outputs: next digit, caption and idle timer values.
    always_comb begin
        digitNxt     = digit;
        txtSelectNxt = txtSelect;
        remainNxt    = remain;
        if (commit) begin
            digitNxt  = pendDigit;
            remainNxt = TIMER_LOAD;
            // Re-committing the digit already on screen keeps its caption.
            if ((state == INSTR) || (pendDigit != digit)) begin
                txtSelectNxt = lfsrMapped;
            end
        end else if (fs && (state == SHOW)) begin
            if (timeoutHit) begin
                txtSelectNxt = 4'd0;
                remainNxt    = 10'd0;
            end else if (TIMER_ENABLED && (remain != 10'd0)) begin
                remainNxt = remain - 10'd1;
            end
        end
    end

    // Registered display outputs and idle timer.
    always_ff @(posedge pixClk or posedge reset) begin
        if (reset) begin
            digit     <= 4'd0;
            digitEn   <= 1'b0;
            txtSelect <= 4'd0;
            remain    <= 10'd0;
        end else begin
            digit     <= digitNxt;
            digitEn   <= (stateNxt == SHOW);
            txtSelect <= txtSelectNxt;
            remain    <= remainNxt;
        end
    end

endmodule
